// File: rtl/sorcerer_cass_pkg.sv
// Shared types and default tick constants for the Sorcerer Kansas City Standard cassette codec.
package sorcerer_cass_pkg;

    typedef enum logic {IDLE, TONE} enc_state_e;

    typedef enum logic [1:0] {SHORT, LONG, GLITCH, OVERLONG} half_cls_e;

    localparam int DEF_HALF1    = 417;
    localparam int DEF_HALF0    = 833;
    localparam int DEF_MIN_HALF = 150;
    localparam int DEF_THRESH   = 625;
    localparam int DEF_MAX_HALF = 1000;

    // Per-source contribution to the speaker monitor mix.
    localparam logic [13:0] AUDIO_LVL = 14'h0800;

endpackage

// File: rtl/sorcerer_cass_filter.sv
// Cassette input conditioning: 2-flop synchroniser, FILT_LEN-sample CEN2 glitch filter, edge strobe.
// edge_stb is asserted in the CEN2 cycle that commits a new filtered level; no backpressure.
module sorcerer_cass_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic CLK12,
    input  logic RESET,
    input  logic CEN2,
    input  logic cass_in,
    output logic filt,
    output logic edge_stb
);
    logic [1:0] sync;
    logic [3:0] diff_cnt;
    logic       samp;

    assign samp     = sync[1];
    assign edge_stb = CEN2 && (samp != filt) && (diff_cnt == 4'(FILT_LEN - 1));

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            sync     <= '0;
            diff_cnt <= '0;
            filt     <= 1'b0;
        end else begin
            sync <= {sync[0], cass_in};
            if (CEN2) begin
                // Any sample matching the current level restarts the run of differing samples.
                if (samp == filt) begin
                    diff_cnt <= '0;
                end else if (edge_stb) begin
                    filt     <= samp;
                    diff_cnt <= '0;
                end else begin
                    diff_cnt <= diff_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sorcerer_cass_codec.sv
// Kansas City Standard cassette codec: FSK encoder, half-period decoder, carrier detect, motor relay.
// Decode results appear one CLK12 after the committing CEN2 sample; no backpressure. Define CASS_AUDIO_EN for AUDIO_MON.
module sorcerer_cass_codec
    import sorcerer_cass_pkg::*;
#(
    parameter int CW        = 10,
    parameter int HALF1     = DEF_HALF1,
    parameter int HALF0     = DEF_HALF0,
    parameter int MIN_HALF  = DEF_MIN_HALF,
    parameter int THRESH    = DEF_THRESH,
    parameter int MAX_HALF  = DEF_MAX_HALF,
    parameter int FILT_LEN  = 4,
    parameter int CARRIER_N = 8
) (
    input  logic        CLK12,
    input  logic        RESET,
    input  logic        CEN2,
    input  logic        CASS_IN,
    input  logic        TX_EN,
    input  logic        TX_BIT,
    input  logic [1:0]  MOTOR,
`ifdef CASS_AUDIO_EN
    output logic [13:0] AUDIO_MON,
`endif
    output logic        CASS_OUT,
    output logic        CASS_CTRL,
    output logic        RX_BIT,
    output logic        RX_STB,
    output logic        CARRIER,
    output logic        ERR
);
    localparam int RW = $clog2(CARRIER_N + 1);
    localparam logic [CW-1:0] C_MIN    = CW'(MIN_HALF);
    localparam logic [CW-1:0] C_THR    = CW'(THRESH);
    localparam logic [CW-1:0] C_MAX    = CW'(MAX_HALF);
    localparam logic [CW-1:0] C_TO     = CW'(MAX_HALF + 1);
    localparam logic [CW-1:0] C_H1     = CW'(HALF1);
    localparam logic [CW-1:0] C_H0     = CW'(HALF0);
    localparam logic [RW-1:0] RUN_FULL = RW'(CARRIER_N);

    logic filt;
    logic edge_stb;

    sorcerer_cass_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .CLK12    (CLK12),
        .RESET    (RESET),
        .CEN2     (CEN2),
        .cass_in  (CASS_IN),
        .filt     (filt),
        .edge_stb (edge_stb)
    );

    logic [CW-1:0] icnt;
    logic [RW-1:0] run;
    logic          to_seen;
    logic          timeout;
    half_cls_e     cls;

    always_comb begin
        if (icnt < C_MIN)       cls = GLITCH;
        else if (icnt < C_THR)  cls = SHORT;
        else if (icnt <= C_MAX) cls = LONG;
        else                    cls = OVERLONG;
    end

    // to_seen limits the timeout to one event per silence; the next edge re-arms it.
    assign timeout = (icnt == C_TO) && !to_seen;
    assign CARRIER = (run == RUN_FULL);

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            icnt      <= '0;
            run       <= '0;
            to_seen   <= 1'b0;
            RX_BIT    <= 1'b1;
            RX_STB    <= 1'b0;
            ERR       <= 1'b0;
            CASS_CTRL <= 1'b0;
        end else begin
            CASS_CTRL <= |MOTOR;
            RX_STB    <= 1'b0;
            ERR       <= 1'b0;
            if (edge_stb) begin
                icnt    <= '0;
                to_seen <= 1'b0;
                unique case (cls)
                    SHORT, LONG: begin
                        RX_BIT <= (cls == SHORT);
                        RX_STB <= 1'b1;
                        if (run != RUN_FULL) run <= run + RW'(1);
                    end
                    GLITCH, OVERLONG: begin
                        ERR <= 1'b1;
                        run <= '0;
                    end
                endcase
            end else begin
                if (CEN2 && icnt != '1) icnt <= icnt + CW'(1);
                if (timeout) begin
                    to_seen <= 1'b1;
                    run     <= '0;
                    RX_BIT  <= 1'b1;
                end
            end
        end
    end

    enc_state_e    state;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] hlen;

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            state    <= IDLE;
            hcnt     <= '0;
            hlen     <= C_H0;
            CASS_OUT <= 1'b0;
        end else if (CEN2) begin
            unique case (state)
                IDLE: begin
                    if (TX_EN) begin
                        CASS_OUT <= 1'b1;
                        hcnt     <= '0;
                        hlen     <= TX_BIT ? C_H1 : C_H0;
                        state    <= TONE;
                    end
                end
                TONE: begin
                    if (!TX_EN) begin
                        CASS_OUT <= 1'b0;
                        state    <= IDLE;
                    end else if (hcnt == hlen - CW'(1)) begin
                        // TX_BIT is only sampled here, keeping the tone phase-continuous.
                        CASS_OUT <= ~CASS_OUT;
                        hcnt     <= '0;
                        hlen     <= TX_BIT ? C_H1 : C_H0;
                    end else begin
                        hcnt <= hcnt + CW'(1);
                    end
                end
            endcase
        end
    end

`ifdef CASS_AUDIO_EN
    always_ff @(posedge CLK12) begin
        if (RESET) AUDIO_MON <= '0;
        else       AUDIO_MON <= (filt ? AUDIO_LVL : 14'h0) + (CASS_OUT ? AUDIO_LVL : 14'h0);
    end
`endif

endmodule

// File: tb/tb_sorcerer_cass_codec.sv
// Directed bench for sorcerer_cass_codec: table of half-period intervals plus encoder/timeout/reset sequences.
module tb_sorcerer_cass_codec;
    localparam int CDIV = 2;
    localparam int CHK  = 8;

    logic       CLK12   = 1'b0;
    logic       RESET   = 1'b1;
    logic       CEN2    = 1'b0;
    logic       CASS_IN = 1'b0;
    logic       TX_EN   = 1'b0;
    logic       TX_BIT  = 1'b0;
    logic [1:0] MOTOR   = 2'b00;
    logic       CASS_OUT, CASS_CTRL, RX_BIT, RX_STB, CARRIER, ERR;
`ifdef CASS_AUDIO_EN
    logic [13:0] AUDIO_MON;
`endif

    sorcerer_cass_codec dut (
        .CLK12     (CLK12),
        .RESET     (RESET),
        .CEN2      (CEN2),
        .CASS_IN   (CASS_IN),
        .TX_EN     (TX_EN),
        .TX_BIT    (TX_BIT),
        .MOTOR     (MOTOR),
`ifdef CASS_AUDIO_EN
        .AUDIO_MON (AUDIO_MON),
`endif
        .CASS_OUT  (CASS_OUT),
        .CASS_CTRL (CASS_CTRL),
        .RX_BIT    (RX_BIT),
        .RX_STB    (RX_STB),
        .CARRIER   (CARRIER),
        .ERR       (ERR)
    );

    initial forever #5 CLK12 = ~CLK12;

    initial begin : cen_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge CLK12);
            ph   = (ph + 1) % CDIV;
            CEN2 = (ph == 0);
        end
    end

    int tick_cnt = 0;
    initial forever begin
        @(posedge CLK12);
        if (CEN2) tick_cnt = tick_cnt + 1;
    end

    // Event monitor: counts RX_STB/ERR pulses and snapshots outputs at each.
    int   ev_n = 0;
    logic ev_err = 1'b0, ev_bit = 1'b0, ev_car = 1'b0;
    int   t_prev = 0, t_last = 0;
    initial forever begin
        @(negedge CLK12);
        if (RX_STB || ERR) begin
            ev_n   = ev_n + 1;
            ev_err = ERR;
            ev_bit = RX_BIT;
            ev_car = CARRIER;
        end
        if (RX_STB) begin
            t_prev = t_last;
            t_last = tick_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int   n;
        int   kind;
        logic b;
        logic car;
        int   gap;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   elapsed = 0;

    function automatic void add(input int n, input int kind, input logic b, input logic car, input int gap);
        vec_t v;
        v.n = n; v.kind = kind; v.b = b; v.car = car; v.gap = gap;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        do @(posedge CLK12); while (CEN2 !== 1'b1);
        #1;
    endtask

    // Hold the current CASS_IN level for v.n ticks, toggle, then score the edge it produces.
    task automatic run_row(input vec_t v, input int idx);
        int kind;
        repeat (v.n - elapsed) tick();
        CASS_IN = ~CASS_IN;
        ev_n = 0;
        repeat (CHK) tick();
        elapsed = CHK;
        if (ev_n == 0)      kind = 0;
        else if (ev_n > 1)  kind = 3;
        else                kind = ev_err ? 2 : 1;
        check($sformatf("row%0d", idx), kind * 4 + int'(ev_bit) * 2 + int'(ev_car),
              v.kind * 4 + int'(v.b) * 2 + int'(v.car));
        if (v.gap != 0) check($sformatf("gap%0d", idx), t_last - t_prev, v.gap);
    endtask

    initial begin : main
        int   tt[3];
        int   nt;
        logic lvl;

        // n ticks between edges; kind 1=RX_STB, 2=ERR; expected RX_BIT, CARRIER; STB spacing.
        add(1100, 2, 1'b1, 1'b0, 0);
        add(150,  2, 1'b1, 1'b0, 0);
        add(151,  1, 1'b1, 1'b0, 0);
        add(625,  1, 1'b1, 1'b0, 0);
        add(626,  1, 1'b0, 1'b0, 0);
        add(1001, 1, 1'b0, 1'b0, 0);
        add(1002, 2, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 8; k++) add(417, 1, 1'b1, (k == 8), (k == 3) ? 417 : 0);
        add(833,  1, 1'b0, 1'b1, 0);
        add(833,  1, 1'b0, 1'b1, 833);
        add(417,  1, 1'b1, 1'b1, 0);
        add(200,  1, 1'b1, 1'b1, 200);
        add(60,   2, 1'b1, 1'b0, 0);
        add(157,  1, 1'b1, 1'b0, 0);
        for (int k = 2; k <= 8; k++) add(417, 1, 1'b1, (k == 8), 0);
        add(833,  1, 1'b0, 1'b1, 0);

        repeat (3) @(posedge CLK12);
        @(negedge CLK12);
        check("reset_outs", {CASS_OUT, CASS_CTRL, RX_BIT, RX_STB, CARRIER, ERR}, 6'b001000);
        RESET = 1'b0;

        MOTOR = 2'b01;
        @(negedge CLK12);
        check("motor01", CASS_CTRL, 1);
        MOTOR = 2'b00;
        @(negedge CLK12);
        check("motor00", CASS_CTRL, 0);

        elapsed = 0;
        for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

        // Silence after carrier with RX_BIT=0: timeout forces mark, drops carrier, no ERR.
        ev_n = 0;
        repeat (1003 - CHK) tick();
        check("pre_timeout", {CARRIER, RX_BIT}, 2'b10);
        repeat (7) tick();
        check("timeout", {CARRIER, RX_BIT}, 2'b01);
        check("timeout_noev", ev_n, 0);

        // 2-tick pulse must not survive the glitch filter.
        ev_n = 0;
        CASS_IN = ~CASS_IN;
        repeat (2) tick();
        CASS_IN = ~CASS_IN;
        repeat (12) tick();
        check("short_pulse", ev_n, 0);
        elapsed = 0;

        // Encoder: TX_BIT change mid-half only affects the following half.
        check("enc_idle", CASS_OUT, 0);
        TX_BIT = 1'b1;
        TX_EN  = 1'b1;
        for (int k = 0; k < 4 && CASS_OUT == 1'b0; k++) tick();
        check("enc_start", CASS_OUT, 1);
        tt[0] = tick_cnt;
        nt    = 1;
        lvl   = 1'b1;
        repeat (200) tick();
        TX_BIT = 1'b0;
        for (int k = 0; k < 2000 && nt < 3; k++) begin
            tick();
            if (CASS_OUT != lvl) begin
                lvl    = CASS_OUT;
                tt[nt] = tick_cnt;
                nt     = nt + 1;
            end
        end
        check("enc_toggles", nt, 3);
        if (nt == 3) begin
            check("enc_half1", tt[1] - tt[0], 417);
            check("enc_half0", tt[2] - tt[1], 833);
        end
        repeat (100) tick();
        check("enc_mid", CASS_OUT, 1);
        TX_EN = 1'b0;
        tick();
        check("enc_stop", CASS_OUT, 0);
        repeat (5) tick();
        check("enc_stay", CASS_OUT, 0);

        // Rebuild carrier with the tone running, then reset mid-tone.
        TX_BIT = 1'b1;
        TX_EN  = 1'b1;
        run_row(vecs[0], 100);
        for (int i = 7; i <= 14; i++) run_row(vecs[i], 100 + i);
        for (int k = 0; k < 900 && CASS_OUT == 1'b0; k++) tick();
        check("tone_high", CASS_OUT, 1);
        @(negedge CLK12);
        MOTOR = 2'b10;
        @(negedge CLK12);
        check("motor10", {CASS_CTRL, CARRIER}, 2'b11);
        RESET = 1'b1;
        @(negedge CLK12);
        check("midreset", {CASS_OUT, CASS_CTRL, RX_BIT, RX_STB, CARRIER, ERR}, 6'b001000);
        RESET = 1'b0;
        TX_EN = 1'b0;
        repeat (4) @(negedge CLK12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sorcerer_cass_codec.md
Name: sorcerer_cass_codec

Overview:
Parametrised Kansas City Standard cassette codec for the Sorcerer core. It replaces the fixed inline edge decoder.
- Demodulates CASS_IN by measuring the half-period between filtered edges: a short half-period is a 1 (2400 Hz), a long one is a 0 (1200 Hz).
- FSK-modulates the UART TX stream onto CASS_OUT with phase-continuous tone switching.
- Adds glitch filtering, carrier detect, timeout and a motor relay output.
- Sits between the cassette pins and the AY-3-1015 UART.

Parameters:
CW, 10, width of half-period counters; all tick constants must be less than 2**CW-1
HALF1, 417, encoder half-period for a 1 (2400 Hz), in CEN2 ticks
HALF0, 833, encoder half-period for a 0 (1200 Hz), in CEN2 ticks
MIN_HALF, 150, decoder: intervals below this are glitches
THRESH, 625, decoder: interval below THRESH decodes 1, otherwise 0
MAX_HALF, 1000, decoder: intervals above this are errors / timeout
FILT_LEN, 4, glitch filter length, in consecutive equal CEN2 samples (2..15)
CARRIER_N, 8, consecutive valid half-periods needed to assert CARRIER

Ports:
CLK12  in  1  system clock, 12 MHz
RESET  in  1  synchronous, active-high
CEN2  in  1  2 MHz clock enable, one CLK12 pulse
CASS_IN  in  1  raw cassette input, asynchronous
TX_EN  in  1  encoder enable
TX_BIT  in  1  UART serial TX level
MOTOR  in  2  motor control bits from port FE
CASS_OUT  out  1  FSK output
CASS_CTRL  out  1  motor relay, registered OR of MOTOR
RX_BIT  out  1  demodulated level to the UART rx pin
RX_STB  out  1  one-CLK12 pulse per valid half-period
CARRIER  out  1  carrier present
ERR  out  1  one-CLK12 pulse on a glitch or over-long interval

Behaviour:
- Reset values: CASS_OUT=0, CASS_CTRL=0, RX_BIT=1, RX_STB=0, CARRIER=0, ERR=0. Counters cleared, encoder in IDLE. Reset mid-tone aborts the tone immediately.
- Input path: 2-flop synchroniser on CLK12. The filtered level changes only after FILT_LEN consecutive equal samples taken on CEN2.
- Edge: the filtered level differs from its previous value. Detection takes 2 CLK12 + FILT_LEN CEN2 ticks.
- Interval counter ICNT:
  - increments on CEN2 and saturates at 2**CW-1;
  - is cleared to 0 on every edge, in the same cycle the edge is classified.
- Classification on edge, using the ICNT value before clearing:
  - ICNT<MIN_HALF: ERR pulse; run counter cleared; CARRIER=0; RX_BIT unchanged; no RX_STB.
  - MIN_HALF<=ICNT<THRESH: RX_BIT=1, RX_STB pulse.
  - THRESH<=ICNT<=MAX_HALF: RX_BIT=0, RX_STB pulse.
  - ICNT>MAX_HALF: same handling as a glitch (ERR, run cleared, CARRIER=0).
- RX_BIT and RX_STB update on the CLK12 cycle following the CEN2 sample that produced the edge.
- Run counter: increments on each valid half-period and saturates at CARRIER_N. CARRIER=1 while run==CARRIER_N.
- Timeout: ICNT reaches MAX_HALF+1 with no edge. Consequences:
  - CARRIER=0, RX_BIT=1 (mark), run=0;
  - one event per silence, no ERR;
  - an edge arriving in the same cycle takes priority and is classified as over-long.
- Encoder FSM, states IDLE and TONE:
  - IDLE: CASS_OUT=0. On the first CEN2 with TX_EN=1: CASS_OUT=1, HCNT=0, latch HLEN from TX_BIT (1 gives HALF1, 0 gives HALF0), go to TONE.
  - TONE: HCNT increments on CEN2. When HCNT==HLEN-1: toggle CASS_OUT, HCNT=0, re-latch HLEN from the current TX_BIT.
  - TX_BIT therefore affects the tone only at half-period boundaries.
  - TX_EN=0 in TONE: go to IDLE on the next CEN2 and drive CASS_OUT=0.
- CASS_CTRL is registered from |MOTOR every CLK12.

Optional Feature:
CASS_AUDIO_EN
- Defined:
  - adds output AUDIO_MON[13:0]: (CASS_IN filtered ? 14'h0800 : 0) + (CASS_OUT ? 14'h0800 : 0), registered on CLK12, reset 0;
  - for speaker monitoring of loads and saves.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sorcerer_cass_pkg:
  - encoder state enum (IDLE, TONE);
  - classification enum (SHORT, LONG, GLITCH, OVERLONG);
  - default tick constants HALF1, HALF0, MIN_HALF, THRESH, MAX_HALF;
  - level constant for AUDIO_MON.
- One sub-module, sorcerer_cass_filter, containing the synchroniser, glitch filter and edge pulse, parametrised by FILT_LEN.

Test Plan:
- 2400 Hz square wave on CASS_IN (417-tick halves) -> RX_STB every 417 CEN2, RX_BIT=1, CARRIER=1 after the 8th valid half.
- Switch to 1200 Hz (833-tick halves) -> RX_BIT=0 on the first long interval, CARRIER stays 1.
- 60-tick pulse inside a 2400 Hz stream -> ERR pulse, no RX_STB, CARRIER=0, back to 1 after 8 more valid halves. A 2-tick pulse is rejected by the filter: no edge, no ERR.
- Silence after carrier -> at ICNT=1001: CARRIER=0, RX_BIT=1, no ERR.
- TX_EN=1, TX_BIT=1, then TX_BIT=0 at tick 200 of a half -> that half still lasts 417, the next lasts 833. TX_EN=0 -> CASS_OUT=0 within 1 CEN2.
- RESET mid-TONE with CARRIER=1 -> next cycle all outputs at reset values. MOTOR=2'b10 -> CASS_CTRL=1 one CLK12 later.
